timer_alarm_scheduler: RTL and testbench

//  Sequences the timer peripheral through an Avalon-MM master port: forwards prescale/enable config, polls
//  the timer count, and compares each snapshot against NUM_ALARMS one-shot alarm compare registers.
//  The CPU programs it through its own Avalon-MM slave; it raises a masked, level interrupt.

---
 rtl/timer_sched_pkg.sv | 31 +++
 rtl/timer_alarm_slot.sv | 32 +++
 rtl/timer_alarm_scheduler.sv | 164 ++++++++++++++++
 tb/tb_timer_alarm_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// Shared constants for the timer alarm scheduler: register map, CTRL fields, timer regs, FSM states.
// Latency: n/a. Backpressure: n/a.
package timer_sched_pkg;
  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_STATUS   = 4'd1;
  localparam logic [3:0] ADDR_IRQ_EN   = 4'd2;
  localparam logic [3:0] ADDR_SNAP     = 4'd3;
  localparam logic [3:0] ADDR_CMP_BASE = 4'd4;

  localparam int CTRL_PRESC_LSB = 0;
  localparam int CTRL_PRESC_W   = 3;
  localparam int CTRL_EN_BIT    = 3;

  localparam logic [1:0] TMR_REG_CTRL  = 2'd0;
  localparam logic [1:0] TMR_REG_COUNT = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_WR,
    ST_POLL_RD,
    ST_POLL_WAIT,
    ST_CHECK
  } state_t;

  // Alarm is reached when the count is at most half the 32-bit range past cmp.
  function automatic logic wrap_reached(input logic [31:0] snap, input logic [31:0] cmp);
    logic [31:0] w_diff;
    w_diff = snap - cmp;
    return !w_diff[31];
  endfunction
endpackage

// File: rtl/timer_alarm_slot.sv
// One-shot alarm channel: compare register, armed flag, wrap-safe reach test; fire is combinational.
// Latency: fire in the CHECK cycle. Backpressure: none; a load in the same cycle suppresses fire.
module timer_alarm_slot
  import timer_sched_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_check,
  input  logic [31:0] i_snap,
  output logic        o_fire,
  output logic [31:0] o_cmp
);
  logic        r_armed;
  logic [31:0] r_cmp;

  assign o_fire = i_check && r_armed && !i_load && wrap_reached(i_snap, r_cmp);
  assign o_cmp  = r_cmp;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_armed <= 1'b0;
      r_cmp   <= '0;
    end else if (i_load) begin
      r_cmp   <= i_load_val;
      r_armed <= 1'b1;
    end else if (o_fire) begin
      r_armed <= 1'b0;
    end
  end
endmodule

// File: rtl/timer_alarm_scheduler.sv
// Polls a timer over an Avalon-MM master, forwards config, fires one-shot alarms; CPU slave, level irq.
// Latency: readdata 1 cycle, poll every 4 cycles. Backpressure: tmr_waitrequest holds the request stable.
module timer_alarm_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_ALARMS = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  address,
  input  logic [31:0] writedata,
  input  logic        write,
  input  logic        read,
  input  logic        chipselect,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  tmr_address,
  output logic [31:0] tmr_writedata,
  output logic        tmr_write,
  output logic        tmr_read,
  output logic        tmr_chipselect,
  input  logic [31:0] tmr_readdata,
  input  logic        tmr_waitrequest,
  output logic        irq
);
  state_t                r_state;
  logic [3:0]            r_ctrl;
  logic                  r_cfg_pend;
  logic [NUM_ALARMS-1:0] r_pending;
  logic [NUM_ALARMS-1:0] r_irq_en;
  logic [31:0]           r_snap;
  logic [31:0]           r_readdata;
  logic                  r_irq;
  logic [1:0]            r_tmr_addr;
  logic [31:0]           r_tmr_wdata;
  logic                  r_tmr_write;
  logic                  r_tmr_read;
  logic                  r_tmr_cs;

  logic                  w_cs_wr;
  logic                  w_ctrl_wr;
  logic                  w_en;
  logic [2:0]            w_presc;
  logic                  w_check;
  logic [NUM_ALARMS-1:0] w_load;
  logic [NUM_ALARMS-1:0] w_fire;
  logic [NUM_ALARMS-1:0] w_w1c;
  logic [31:0]           w_cmp [NUM_ALARMS];
  logic [31:0]           w_rd;

  assign w_cs_wr   = chipselect && write;
  assign w_ctrl_wr = w_cs_wr && (address == ADDR_CTRL);
  assign w_en      = r_ctrl[CTRL_EN_BIT];
  assign w_presc   = r_ctrl[CTRL_PRESC_LSB +: CTRL_PRESC_W];
  assign w_check   = (r_state == ST_CHECK);
  assign w_w1c     = (w_cs_wr && address == ADDR_STATUS) ? writedata[NUM_ALARMS-1:0] : '0;

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
    assign w_load[g] = w_cs_wr && (address == ADDR_CMP_BASE + 4'(g));
    timer_alarm_slot u_slot (
      .clock      (clock),
      .resetn     (resetn),
      .i_load     (w_load[g]),
      .i_load_val (writedata),
      .i_check    (w_check),
      .i_snap     (r_snap),
      .o_fire     (w_fire[g]),
      .o_cmp      (w_cmp[g])
    );
  end

  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_CTRL:   w_rd[3:0] = r_ctrl;
      ADDR_STATUS: w_rd[NUM_ALARMS-1:0] = r_pending;
      ADDR_IRQ_EN: w_rd[NUM_ALARMS-1:0] = r_irq_en;
      ADDR_SNAP:   w_rd = r_snap;
      default: begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
          if (address == ADDR_CMP_BASE + 4'(i)) w_rd = w_cmp[i];
        end
      end
    endcase
  end

  // A fire and a W1C of the same bit in one cycle leaves the bit set.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ctrl     <= '0;
      r_irq_en   <= '0;
      r_pending  <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ctrl <= writedata[3:0];
      if (w_cs_wr && address == ADDR_IRQ_EN) r_irq_en <= writedata[NUM_ALARMS-1:0];
      r_pending  <= (r_pending & ~w_w1c) | w_fire;
      r_readdata <= (chipselect && read) ? w_rd : '0;
      r_irq      <= |(r_pending & r_irq_en);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cfg_pend  <= 1'b0;
      r_snap      <= '0;
      r_tmr_addr  <= '0;
      r_tmr_wdata <= '0;
      r_tmr_write <= 1'b0;
      r_tmr_read  <= 1'b0;
      r_tmr_cs    <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_cfg_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_cfg_pend) begin
            r_state     <= ST_CFG_WR;
            r_tmr_cs    <= 1'b1;
            r_tmr_write <= 1'b1;
            r_tmr_addr  <= TMR_REG_CTRL;
            r_tmr_wdata <= {29'b0, w_en ? w_presc : 3'b0};
          end else if (w_en) begin
            r_state    <= ST_POLL_RD;
            r_tmr_cs   <= 1'b1;
            r_tmr_read <= 1'b1;
            r_tmr_addr <= TMR_REG_COUNT;
          end
        end
        ST_CFG_WR: begin
          if (!tmr_waitrequest) begin
            if (!w_ctrl_wr) r_cfg_pend <= 1'b0;
            r_state     <= ST_IDLE;
            r_tmr_cs    <= 1'b0;
            r_tmr_write <= 1'b0;
          end
        end
        ST_POLL_RD: begin
          if (!tmr_waitrequest) begin
            r_state    <= ST_POLL_WAIT;
            r_tmr_cs   <= 1'b0;
            r_tmr_read <= 1'b0;
          end
        end
        ST_POLL_WAIT: begin
          r_snap  <= tmr_readdata;
          r_state <= ST_CHECK;
        end
        ST_CHECK: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign readdata       = r_readdata;
  assign waitrequest    = 1'b0;
  assign tmr_address    = r_tmr_addr;
  assign tmr_writedata  = r_tmr_wdata;
  assign tmr_write      = r_tmr_write;
  assign tmr_read       = r_tmr_read;
  assign tmr_chipselect = r_tmr_cs;
  assign irq            = r_irq;
endmodule

// File: tb/tb_timer_alarm_scheduler.sv
// Directed plus randomized bench for timer_alarm_scheduler with a behavioural alarm model.
module tb_timer_alarm_scheduler;
  localparam int N = 4;

  logic        clock;
  logic        resetn;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic        write, read, chipselect;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [1:0]  tmr_address;
  logic [31:0] tmr_writedata;
  logic        tmr_write, tmr_read, tmr_chipselect;
  logic [31:0] tmr_readdata;
  logic        tmr_waitrequest;
  logic        irq;

  timer_alarm_scheduler #(.NUM_ALARMS(N)) dut (
    .clock(clock), .resetn(resetn), .address(address), .writedata(writedata),
    .write(write), .read(read), .chipselect(chipselect), .readdata(readdata),
    .waitrequest(waitrequest), .tmr_address(tmr_address), .tmr_writedata(tmr_writedata),
    .tmr_write(tmr_write), .tmr_read(tmr_read), .tmr_chipselect(tmr_chipselect),
    .tmr_readdata(tmr_readdata), .tmr_waitrequest(tmr_waitrequest), .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Timer-side transaction log
  logic [31:0] wr_d[$];
  logic [1:0]  wr_a[$];
  int          rd_t[$];
  bit          rd_addr_bad = 1'b0;
  always @(posedge clock) begin
    if (resetn && tmr_chipselect && !tmr_waitrequest) begin
      if (tmr_write) begin
        wr_d.push_back(tmr_writedata);
        wr_a.push_back(tmr_address);
      end
      if (tmr_read) begin
        rd_t.push_back(cyc);
        if (tmr_address != 2'd1) rd_addr_bad <= 1'b1;
      end
    end
  end

  // Behavioural model state
  logic [31:0] m_cmp [N];
  bit          m_armed [N];
  logic [N-1:0] m_pend, m_irqen;
  logic [31:0] m_count;

  function automatic bit m_reached(input logic [31:0] s, input logic [31:0] c);
    longint d;
    d = longint'(s) - longint'(c);
    if (d < 0) d = d + 64'sd4294967296;
    return d < 64'sd2147483648;
  endfunction

  task automatic m_settle();
    for (int i = 0; i < N; i++) begin
      if (m_armed[i] && m_reached(m_count, m_cmp[i])) begin
        m_pend[i]  = 1'b1;
        m_armed[i] = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1; chipselect = 1'b1;
    @(negedge clock);
    write = 1'b0; chipselect = 1'b0;
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [31:0] d);
    address = a; read = 1'b1; chipselect = 1'b1;
    @(negedge clock);
    read = 1'b0; chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_tmr_write(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clock);
      if (tmr_write) ok = 1'b1;
    end
    check(tag, {31'b0, ok}, 32'd1);
  endtask

  task automatic check_state(input string tag);
    logic [31:0] d;
    cpu_rd(4'd1, d);
    check({tag, "_status"}, d, {28'b0, m_pend});
    check({tag, "_irq"}, {31'b0, irq}, {31'b0, |(m_pend & m_irqen)});
  endtask

  initial begin
    logic [31:0] d;
    int n0;
    bit seen;
    resetn = 1'b0; address = '0; writedata = '0; write = 1'b0; read = 1'b0; chipselect = 1'b0;
    tmr_readdata = '0; tmr_waitrequest = 1'b0;
    for (int i = 0; i < N; i++) begin m_cmp[i] = '0; m_armed[i] = 1'b0; end
    m_pend = '0; m_irqen = '0; m_count = '0;

    // Reset state
    idle(3);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_tmr_strobes", {29'b0, tmr_chipselect, tmr_read, tmr_write}, 32'd0);
    check("rst_tmr_wdata", tmr_writedata, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("waitrequest", {31'b0, waitrequest}, 32'd0);
    resetn = 1'b1;
    idle(2);
    cpu_wr(4'hF, 32'hFFFF_FFFF);
    for (int a = 0; a < 16; a++) begin
      cpu_rd(4'(a), d);
      check($sformatf("rst_read_%0d", a), d, 32'd0);
    end
    check("rst_no_tmr_traffic", wr_d.size() + rd_t.size(), 32'd0);

    // Config forwarding and poll cadence
    cpu_wr(4'd0, 32'hA);
    idle(30);
    check("cfg_wr_cnt", wr_d.size(), 32'd1);
    if (wr_d.size() >= 1) begin
      check("cfg_wr_dat", wr_d[0], 32'h2);
      check("cfg_wr_adr", {30'b0, wr_a[0]}, 32'd0);
    end
    n0 = rd_t.size();
    check("poll_seen", {31'b0, n0 >= 4}, 32'd1);
    if (n0 >= 3) begin
      check("poll_period_a", rd_t[n0-1] - rd_t[n0-2], 32'd4);
      check("poll_period_b", rd_t[n0-2] - rd_t[n0-3], 32'd4);
    end
    check("poll_addr", {31'b0, rd_addr_bad}, 32'd0);

    // Alarm 0 at 100: 99 does not fire, 104 does, W1C clears with no refire
    tmr_readdata = 32'd99;
    idle(12);
    cpu_wr(4'd4, 32'd100);
    cpu_wr(4'd2, 32'd1);
    idle(12);
    cpu_rd(4'd1, d);
    check("a0_before", d, 32'd0);
    check("a0_before_irq", {31'b0, irq}, 32'd0);
    tmr_readdata = 32'd104;
    idle(12);
    cpu_rd(4'd1, d);
    check("a0_fired", d, 32'd1);
    check("a0_irq", {31'b0, irq}, 32'd1);
    cpu_wr(4'd1, 32'd1);
    idle(12);
    cpu_rd(4'd1, d);
    check("a0_cleared", d, 32'd0);
    check("a0_irq_clr", {31'b0, irq}, 32'd0);

    // Wrap-safe compare across 2^32
    tmr_readdata = 32'hFFFF_FFE0;
    idle(12);
    cpu_wr(4'd5, 32'hFFFF_FFF0);
    idle(12);
    cpu_rd(4'd1, d);
    check("wrap_before", d, 32'd0);
    tmr_readdata = 32'h10;
    idle(12);
    cpu_rd(4'd1, d);
    check("wrap_fired", d, 32'd2);
    check("wrap_irq_masked", {31'b0, irq}, 32'd0);
    cpu_wr(4'd1, 32'd2);

    // Stall on the poll read
    tmr_readdata = 32'h1234_5678;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (tmr_read) seen = 1'b1;
    end
    check("stall_found_read", {31'b0, seen}, 32'd1);
    tmr_waitrequest = 1'b1;
    n0 = rd_t.size();
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("stall_hold_%0d", k),
            {28'b0, tmr_chipselect, tmr_read, tmr_write, tmr_address == 2'd1}, 32'b1101);
    end
    tmr_waitrequest = 1'b0;
    @(negedge clock);
    check("stall_one_accept", rd_t.size() - n0, 32'd1);
    idle(4);
    cpu_wr(4'd3, 32'hDEAD_BEEF);
    cpu_rd(4'd3, d);
    check("snap_value", d, 32'h1234_5678);

    // CTRL write landing in the cycle CFG_WR completes
    cpu_wr(4'd0, 32'h9);
    wait_tmr_write("race_find_cfg");
    n0 = wr_d.size();
    cpu_wr(4'd0, 32'hB);
    idle(20);
    check("race_wr_cnt", wr_d.size() - n0, 32'd2);
    if (wr_d.size() >= n0 + 2) begin
      check("race_wr_first", wr_d[n0], 32'h1);
      check("race_wr_second", wr_d[n0+1], 32'h3);
    end

    // Disable: timer gets 0 and polling stops
    cpu_wr(4'd0, 32'h2);
    wait_tmr_write("dis_find_cfg");
    idle(2);
    if (wr_d.size() >= 1) check("dis_wr_dat", wr_d[wr_d.size()-1], 32'h0);
    n0 = rd_t.size();
    idle(20);
    check("dis_no_polls", rd_t.size() - n0, 32'd0);

    // Randomized phase against the model
    cpu_wr(4'd0, 32'h8);
    cpu_wr(4'd1, 32'hF);
    m_irqen = 4'($urandom);
    cpu_wr(4'd2, {28'b0, m_irqen});
    m_count = tmr_readdata;
    idle(12);
    for (int t = 0; t < 40; t++) begin
      int op;
      int s;
      logic [31:0] v;
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          s = $urandom_range(0, N-1);
          v = m_count + 32'($urandom_range(0, 64)) - 32'd32;
          cpu_wr(4'(4 + s), v);
          m_cmp[s] = v;
          m_armed[s] = 1'b1;
          cpu_rd(4'(4 + s), d);
          check($sformatf("rnd%0d_cmp_rb", t), d, v);
        end
        1: begin
          v = 32'($urandom_range(0, 15));
          cpu_wr(4'd1, v);
          m_pend = m_pend & ~v[N-1:0];
        end
        2: begin
          m_irqen = 4'($urandom);
          cpu_wr(4'd2, {28'b0, m_irqen});
        end
        default: begin
          if ($urandom_range(0, 3) == 0) m_count = $urandom;
          else m_count = m_count + 32'($urandom_range(0, 40));
          tmr_readdata = m_count;
        end
      endcase
      idle(12);
      m_settle();
      check_state($sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
